zap_sram_arbiter: RTL and testbench

Two-port arbiter that shares the single-port synchronous SRAM between the ZAP instruction-fetch port and the ZAP data port. It grants at most one SRAM access per cycle, acknowledging the winner in the same cycle. It steers the SRAM's one-cycle-latency read data back to whichever port issued the read. Data accesses have priority; a configurable starvation guard forces an instruction grant so fetch always makes progress.

---
 rtl/zap_sram_arbiter.sv | 143 ++++++++++++++
 tb/tb_zap_sram_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zap_sram_arbiter.sv
// ---------------------------------------------------------------------------
// zap_sram_arbiter
//
// Shares one single-port synchronous SRAM between the ZAP instruction-fetch
// port and the ZAP data port. At most one access is issued per cycle and the
// winner is acknowledged in that same cycle. Read data comes back from the
// SRAM one cycle later and is flagged valid only on the port that issued the
// read.
//
// Data accesses normally win. A 4-bit streak counter tracks consecutive data
// grants made while a fetch is waiting. Once it reaches STARVE_LIMIT the next
// contended cycle goes to the fetch port, so fetch always makes progress.
//
// Parameters
//   STARVE_LIMIT  max consecutive data grants while a fetch waits (1..15)
//
// Ports
//   i_clk, i_reset          clock, asynchronous active-high reset
//   i_ireq, i_iaddress      fetch request / address
//   o_iack                  fetch issued this cycle (combinational)
//   o_irdata, o_irvalid     fetch read data / valid (valid registered)
//   i_dreq, i_dwr_en        data request / write select
//   i_daddress, i_dben      data address / write byte enables
//   i_dwdata                data write data
//   o_dack                  data access issued this cycle (combinational)
//   o_drdata, o_drvalid     data read data / valid (reads only, registered)
//   o_mem_*                 SRAM command: enable, write strobe, address,
//                           byte enables, write data
//   i_mem_rdata             SRAM read data, one cycle after a read
//
// Handshake: a requester raises its req with address/data stable and holds
// them until the cycle in which its ack is high; that cycle is the transfer.
// A new request may be presented in the very next cycle, so back-to-back
// accesses to the same port run with no bubble. A read's valid rises exactly
// one cycle after its ack and stays high for one cycle.
// ---------------------------------------------------------------------------
module zap_sram_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        i_clk,
   input  logic        i_reset,

   input  logic        i_ireq,
   input  logic [31:0] i_iaddress,
   output logic        o_iack,
   output logic [31:0] o_irdata,
   output logic        o_irvalid,

   input  logic        i_dreq,
   input  logic        i_dwr_en,
   input  logic [31:0] i_daddress,
   input  logic [3:0]  i_dben,
   input  logic [31:0] i_dwdata,
   output logic        o_dack,
   output logic [31:0] o_drdata,
   output logic        o_drvalid,

   output logic        o_mem_en,
   output logic        o_mem_wr_en,
   output logic [31:0] o_mem_addr,
   output logic [3:0]  o_mem_ben,
   output logic [31:0] o_mem_wdata,
   input  logic [31:0] i_mem_rdata
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [3:0] streak;
   logic       grant_i;
   logic       grant_d;

   // Arbitration. Gated by reset so no strobe can leak out while the block
   // is held in reset, even with requests asserted.
   always_comb begin
      grant_i = 1'b0;
      grant_d = 1'b0;
      if (!i_reset) begin
         if (i_ireq && i_dreq) begin
            if (streak == LIMIT) begin
               grant_i = 1'b1;
            end else begin
               grant_d = 1'b1;
            end
         end else begin
            grant_i = i_ireq;
            grant_d = i_dreq;
         end
      end
   end

   assign o_iack = grant_i;
   assign o_dack = grant_d;

   // SRAM command mux. Idle cycles drive an all-zero command so the bus is
   // quiet and easy to read in a trace.
   always_comb begin
      o_mem_en    = 1'b0;
      o_mem_wr_en = 1'b0;
      o_mem_addr  = 32'd0;
      o_mem_ben   = 4'd0;
      o_mem_wdata = 32'd0;
      if (grant_i) begin
         o_mem_en   = 1'b1;
         o_mem_addr = i_iaddress;
      end else if (grant_d) begin
         o_mem_en    = 1'b1;
         o_mem_wr_en = i_dwr_en;
         o_mem_addr  = i_daddress;
         if (i_dwr_en) begin
            o_mem_ben   = i_dben;
            o_mem_wdata = i_dwdata;
         end
      end
   end

   // Both ports see the raw SRAM output; the valid flags say who owns it.
   assign o_irdata = i_mem_rdata;
   assign o_drdata = i_mem_rdata;

   // Streak counter and return tracking. The asynchronous clear also drops
   // the valid of any read in flight, so a read acked just before reset
   // never reports data.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         streak    <= 4'd0;
         o_irvalid <= 1'b0;
         o_drvalid <= 1'b0;
      end else begin
         o_irvalid <= grant_i;
         o_drvalid <= grant_d & ~i_dwr_en;
         // Only data grants that made a waiting fetch wait count; a fetch
         // grant or an idle fetch port restarts the count.
         if (grant_d && i_ireq) begin
            if (streak != LIMIT) begin
               streak <= streak + 4'd1;
            end
         end else begin
            streak <= 4'd0;
         end
      end
   end

endmodule

// File: tb/tb_zap_sram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_zap_sram_arbiter
//
// Bench for zap_sram_arbiter with STARVE_LIMIT = 4. A behavioural SRAM sits
// on the memory port. A reference model (word array, streak count and
// expected-return queues) predicts grants and read data from the arbitration
// rules. Directed scenarios are followed by a randomized request stream with
// hold-until-ack requesters.
// ---------------------------------------------------------------------------
module tb_zap_sram_arbiter;

   localparam int LIMIT = 4;

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT signals ----------------
   logic        ireq, iack, irvalid;
   logic [31:0] iaddr, irdata;
   logic        dreq, dwr, dack, drvalid;
   logic [31:0] daddr, dwdata, drdata;
   logic [3:0]  dben;
   logic        mem_en, mem_wr;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_ben;

   zap_sram_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .i_clk       (clk),
      .i_reset     (rst),
      .i_ireq      (ireq),
      .i_iaddress  (iaddr),
      .o_iack      (iack),
      .o_irdata    (irdata),
      .o_irvalid   (irvalid),
      .i_dreq      (dreq),
      .i_dwr_en    (dwr),
      .i_daddress  (daddr),
      .i_dben      (dben),
      .i_dwdata    (dwdata),
      .o_dack      (dack),
      .o_drdata    (drdata),
      .o_drvalid   (drvalid),
      .o_mem_en    (mem_en),
      .o_mem_wr_en (mem_wr),
      .o_mem_addr  (mem_addr),
      .o_mem_ben   (mem_ben),
      .o_mem_wdata (mem_wdata),
      .i_mem_rdata (mem_rdata)
   );

   // ---------------- behavioural SRAM ----------------
   logic [31:0] sram [0:4095];
   logic        fill_all;
   logic        pl_we;
   logic [11:0] pl_idx;
   logic [31:0] pl_data;

   function automatic logic [31:0] init_word(input int i);
      return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
   endfunction

   always @(posedge clk) begin
      if (fill_all) begin
         for (int i = 0; i < 4096; i++) sram[i] <= init_word(i);
      end else if (pl_we) begin
         sram[pl_idx] <= pl_data;
      end else if (mem_en) begin
         if (mem_wr) begin
            for (int b = 0; b < 4; b++)
               if (mem_ben[b]) sram[mem_addr[13:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
         end else begin
            mem_rdata <= sram[mem_addr[13:2]];
         end
      end
   end

   // ---------------- reference model / scoreboard ----------------
   int          checks   = 0;
   int          failures = 0;
   logic [31:0] ref_mem [0:4095];
   logic [31:0] exp_iq[$];
   logic [31:0] exp_dq[$];
   int          ref_streak = 0;

   // 0 = no grant, 1 = fetch, 2 = data. Fetch wins if alone or once the
   // data port has already taken LIMIT grants while it waited.
   function automatic int predict();
      if (ireq && (!dreq || ref_streak >= LIMIT)) return 1;
      if (dreq) return 2;
      return 0;
   endfunction

   task automatic commit(input int g);
      if (g == 2 && ireq) ref_streak = (ref_streak + 1 > LIMIT) ? LIMIT : ref_streak + 1;
      else                ref_streak = 0;
      if (g == 1) exp_iq.push_back(ref_mem[iaddr[13:2]]);
      if (g == 2 && !dwr) exp_dq.push_back(ref_mem[daddr[13:2]]);
      if (g == 2 && dwr)
         for (int b = 0; b < 4; b++)
            if (dben[b]) ref_mem[daddr[13:2]][8*b +: 8] = dwdata[8*b +: 8];
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                        input logic w, input logic [31:0] da, input logic [3:0] be,
                        input logic [31:0] wd);
      ireq = ir; iaddr = ia; dreq = dr; dwr = w; daddr = da; dben = be; dwdata = wd;
   endtask

   task automatic drive_idle();
      drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
   endtask

   task automatic preload(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      pl_we = 1'b1; pl_idx = a[13:2]; pl_data = d;
      ref_mem[a[13:2]] = d;
      @(negedge clk);
      pl_we = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1;
      drive(1'b1, 32'h40, 1'b1, 1'b1, 32'h80, 4'hF, 32'h1234_5678);
      repeat (3) begin
         @(negedge clk);
         checks++; if (iack !== 1'b0)    begin failures++; $display("FAIL reset_iack got=%b exp=0", iack); end
         checks++; if (dack !== 1'b0)    begin failures++; $display("FAIL reset_dack got=%b exp=0", dack); end
         checks++; if (mem_en !== 1'b0)  begin failures++; $display("FAIL reset_mem_en got=%b exp=0", mem_en); end
         checks++; if (mem_wr !== 1'b0)  begin failures++; $display("FAIL reset_mem_wr got=%b exp=0", mem_wr); end
         checks++; if (irvalid !== 1'b0) begin failures++; $display("FAIL reset_irvalid got=%b exp=0", irvalid); end
         checks++; if (drvalid !== 1'b0) begin failures++; $display("FAIL reset_drvalid got=%b exp=0", drvalid); end
      end
      drive_idle();
      rst = 1'b0;
   endtask

   task automatic test_instr_only();
      preload(32'h100, 32'hE3A0_0001);
      @(negedge clk);
      drive(1'b1, 32'h100, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
      #1;
      checks++; if (iack !== 1'b1)          begin failures++; $display("FAIL instr_iack got=%b exp=1", iack); end
      checks++; if (dack !== 1'b0)          begin failures++; $display("FAIL instr_dack got=%b exp=0", dack); end
      checks++; if (mem_en !== 1'b1)        begin failures++; $display("FAIL instr_mem_en got=%b exp=1", mem_en); end
      checks++; if (mem_wr !== 1'b0)        begin failures++; $display("FAIL instr_mem_wr got=%b exp=0", mem_wr); end
      checks++; if (mem_addr !== 32'h100)   begin failures++; $display("FAIL instr_addr got=%h exp=00000100", mem_addr); end
      checks++; if (mem_ben !== 4'd0)       begin failures++; $display("FAIL instr_ben got=%b exp=0000", mem_ben); end
      @(negedge clk);
      drive_idle();
      checks++; if (irvalid !== 1'b1)       begin failures++; $display("FAIL instr_irvalid got=%b exp=1", irvalid); end
      checks++; if (irdata !== 32'hE3A0_0001) begin failures++; $display("FAIL instr_irdata got=%h exp=e3a00001", irdata); end
      checks++; if (drvalid !== 1'b0)       begin failures++; $display("FAIL instr_drvalid got=%b exp=0", drvalid); end
      @(negedge clk);
      checks++; if (irvalid !== 1'b0)       begin failures++; $display("FAIL instr_irvalid_drop got=%b exp=0", irvalid); end
   endtask

   task automatic test_data_wr_rd();
      preload(32'h1770, 32'h1122_3344);
      @(negedge clk);
      drive(1'b0, 32'd0, 1'b1, 1'b1, 32'h1770, 4'b0011, 32'hDEAD_BEEF);
      #1;
      checks++; if (dack !== 1'b1)             begin failures++; $display("FAIL wr_dack got=%b exp=1", dack); end
      checks++; if (iack !== 1'b0)             begin failures++; $display("FAIL wr_iack got=%b exp=0", iack); end
      checks++; if (mem_wr !== 1'b1)           begin failures++; $display("FAIL wr_strobe got=%b exp=1", mem_wr); end
      checks++; if (mem_ben !== 4'b0011)       begin failures++; $display("FAIL wr_ben got=%b exp=0011", mem_ben); end
      checks++; if (mem_addr !== 32'h1770)     begin failures++; $display("FAIL wr_addr got=%h exp=00001770", mem_addr); end
      checks++; if (mem_wdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wr_wdata got=%h exp=deadbeef", mem_wdata); end
      ref_mem[12'h5DC][15:0] = 16'hBEEF;
      @(negedge clk);
      checks++; if (drvalid !== 1'b0)          begin failures++; $display("FAIL wr_no_drvalid got=%b exp=0", drvalid); end
      drive(1'b0, 32'd0, 1'b1, 1'b0, 32'h1770, 4'b1111, 32'h0);
      #1;
      checks++; if (dack !== 1'b1)             begin failures++; $display("FAIL rd_dack got=%b exp=1", dack); end
      checks++; if (mem_wr !== 1'b0)           begin failures++; $display("FAIL rd_strobe got=%b exp=0", mem_wr); end
      checks++; if (mem_ben !== 4'd0)          begin failures++; $display("FAIL rd_ben got=%b exp=0000", mem_ben); end
      @(negedge clk);
      drive_idle();
      checks++; if (drvalid !== 1'b1)          begin failures++; $display("FAIL rd_drvalid got=%b exp=1", drvalid); end
      checks++; if (drdata !== 32'h1122_BEEF)  begin failures++; $display("FAIL rd_drdata got=%h exp=1122beef", drdata); end
      checks++; if (irvalid !== 1'b0)          begin failures++; $display("FAIL rd_irvalid got=%b exp=0", irvalid); end
      @(negedge clk);
      checks++; if (drvalid !== 1'b0)          begin failures++; $display("FAIL rd_drvalid_drop got=%b exp=0", drvalid); end
   endtask

   task automatic test_contention();
      logic pi, pd, ei;
      pi = 1'b0; pd = 1'b0;
      @(negedge clk);
      drive_idle();
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         checks++; if (irvalid !== pi) begin failures++; $display("FAIL cont_irvalid cyc=%0d got=%b exp=%b", k, irvalid, pi); end
         checks++; if (drvalid !== pd) begin failures++; $display("FAIL cont_drvalid cyc=%0d got=%b exp=%b", k, drvalid, pd); end
         drive(1'b1, 32'h100, 1'b1, 1'b0, 32'h1770, 4'd0, 32'd0);
         #1;
         ei = (k % (LIMIT + 1) == 0);
         checks++; if (iack !== ei)  begin failures++; $display("FAIL cont_iack cyc=%0d got=%b exp=%b", k, iack, ei); end
         checks++; if (dack !== !ei) begin failures++; $display("FAIL cont_dack cyc=%0d got=%b exp=%b", k, dack, !ei); end
         pi = ei; pd = !ei;
      end
      @(negedge clk);
      drive_idle();
      checks++; if (irvalid !== pi) begin failures++; $display("FAIL cont_irvalid_last got=%b exp=%b", irvalid, pi); end
   endtask

   task automatic test_streak_clear();
      logic ei;
      @(negedge clk);
      drive_idle();
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         drive(k != 4, 32'h100, 1'b1, 1'b0, 32'h1770, 4'd0, 32'd0);
         #1;
         // 3 data grants, fetch drops (count restarts), then 4 more before fetch wins
         ei = (k == 9);
         checks++; if (iack !== ei)  begin failures++; $display("FAIL clr_iack cyc=%0d got=%b exp=%b", k, iack, ei); end
         checks++; if (dack !== !ei) begin failures++; $display("FAIL clr_dack cyc=%0d got=%b exp=%b", k, dack, !ei); end
      end
      @(negedge clk);
      drive_idle();
   endtask

   task automatic test_reset_mid_read();
      @(negedge clk);
      drive(1'b0, 32'd0, 1'b1, 1'b0, 32'h1770, 4'd0, 32'd0);
      #1;
      checks++; if (dack !== 1'b1)   begin failures++; $display("FAIL rmr_dack got=%b exp=1", dack); end
      #2 rst = 1'b1;
      #1;
      checks++; if (dack !== 1'b0)   begin failures++; $display("FAIL rmr_dack_in_reset got=%b exp=0", dack); end
      checks++; if (mem_en !== 1'b0) begin failures++; $display("FAIL rmr_mem_en_in_reset got=%b exp=0", mem_en); end
      checks++; if (mem_wr !== 1'b0) begin failures++; $display("FAIL rmr_mem_wr_in_reset got=%b exp=0", mem_wr); end
      @(negedge clk);
      checks++; if (drvalid !== 1'b0) begin failures++; $display("FAIL rmr_drvalid got=%b exp=0", drvalid); end
      checks++; if (irvalid !== 1'b0) begin failures++; $display("FAIL rmr_irvalid got=%b exp=0", irvalid); end
      drive_idle();
      rst = 1'b0;
      @(negedge clk);
      checks++; if (drvalid !== 1'b0) begin failures++; $display("FAIL rmr_drvalid_after got=%b exp=0", drvalid); end
      drive(1'b0, 32'd0, 1'b1, 1'b0, 32'h1770, 4'd0, 32'd0);
      #1;
      checks++; if (dack !== 1'b1)          begin failures++; $display("FAIL rmr_first_dack got=%b exp=1", dack); end
      checks++; if (mem_addr !== 32'h1770)  begin failures++; $display("FAIL rmr_first_addr got=%h exp=00001770", mem_addr); end
      @(negedge clk);
      drive_idle();
      checks++; if (drvalid !== 1'b1)         begin failures++; $display("FAIL rmr_first_drvalid got=%b exp=1", drvalid); end
      checks++; if (drdata !== 32'h1122_BEEF) begin failures++; $display("FAIL rmr_first_drdata got=%h exp=1122beef", drdata); end
      @(negedge clk);
      checks++; if (drvalid !== 1'b0)         begin failures++; $display("FAIL rmr_drvalid_drop got=%b exp=0", drvalid); end
   endtask

   task automatic test_idle();
      int idx [4];
      idx[0] = 12'h040; idx[1] = 12'h5DC; idx[2] = 12'h020; idx[3] = 12'h010;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         // Request lines low but the rest of the bus busy: must stay silent.
         drive(1'b0, $urandom, 1'b0, 1'b1, $urandom, 4'hF, $urandom);
         #1;
         checks++; if (mem_en !== 1'b0)    begin failures++; $display("FAIL idle_mem_en cyc=%0d got=%b exp=0", k, mem_en); end
         checks++; if (mem_wr !== 1'b0)    begin failures++; $display("FAIL idle_mem_wr cyc=%0d got=%b exp=0", k, mem_wr); end
         checks++; if ((iack | dack) !== 1'b0) begin failures++; $display("FAIL idle_ack cyc=%0d got=%b%b exp=00", k, iack, dack); end
         checks++; if ({mem_addr, mem_ben, mem_wdata} !== 68'd0) begin failures++; $display("FAIL idle_bus cyc=%0d addr=%h ben=%b wdata=%h exp=0", k, mem_addr, mem_ben, mem_wdata); end
         checks++; if ((irvalid | drvalid) !== 1'b0) begin failures++; $display("FAIL idle_valid cyc=%0d got=%b%b exp=00", k, irvalid, drvalid); end
      end
      @(negedge clk);
      drive_idle();
      for (int j = 0; j < 4; j++) begin
         checks++; if (sram[idx[j]] !== ref_mem[idx[j]]) begin failures++; $display("FAIL idle_sram idx=%h got=%h exp=%h", idx[j], sram[idx[j]], ref_mem[idx[j]]); end
      end
   endtask

   task automatic test_random();
      logic        ip, dp, w;
      logic [31:0] ia, da, wd, e;
      logic [3:0]  be;
      int          g, iwait;
      ip = 0; dp = 0; w = 0; ia = 0; da = 0; wd = 0; be = 0; iwait = 0;
      @(negedge clk);
      drive_idle();
      ref_streak = 0;
      exp_iq.delete(); exp_dq.delete();
      for (int n = 0; n <= 400; n++) begin
         @(negedge clk);
         checks++; if (irvalid !== (exp_iq.size() != 0)) begin failures++; $display("FAIL rnd_irvalid n=%0d got=%b exp=%b", n, irvalid, exp_iq.size() != 0); end
         if (exp_iq.size() != 0) begin
            e = exp_iq.pop_front();
            checks++; if (irdata !== e) begin failures++; $display("FAIL rnd_irdata n=%0d got=%h exp=%h", n, irdata, e); end
         end
         checks++; if (drvalid !== (exp_dq.size() != 0)) begin failures++; $display("FAIL rnd_drvalid n=%0d got=%b exp=%b", n, drvalid, exp_dq.size() != 0); end
         if (exp_dq.size() != 0) begin
            e = exp_dq.pop_front();
            checks++; if (drdata !== e) begin failures++; $display("FAIL rnd_drdata n=%0d got=%h exp=%h", n, drdata, e); end
         end
         if (n == 400) begin
            drive_idle();
            break;
         end
         if (!ip && $urandom_range(0, 3) != 0) begin
            ip = 1; ia = 32'h2000 + 32'(4 * $urandom_range(0, 15)); iwait = 0;
         end
         if (!dp && $urandom_range(0, 4) != 0) begin
            dp = 1; w = 1'($urandom_range(0, 1)); da = 32'h2000 + 32'(4 * $urandom_range(0, 15));
            be = 4'($urandom_range(0, 15)); wd = $urandom;
         end
         drive(ip, ia, dp, w, da, be, wd);
         #1;
         g = predict();
         checks++; if (iack !== (g == 1)) begin failures++; $display("FAIL rnd_iack n=%0d got=%b exp=%b", n, iack, g == 1); end
         checks++; if (dack !== (g == 2)) begin failures++; $display("FAIL rnd_dack n=%0d got=%b exp=%b", n, dack, g == 2); end
         checks++; if (mem_en !== (g != 0)) begin failures++; $display("FAIL rnd_mem_en n=%0d got=%b exp=%b", n, mem_en, g != 0); end
         if (g == 1) begin
            checks++; if ({mem_wr, mem_addr, mem_ben} !== {1'b0, ia, 4'd0}) begin failures++; $display("FAIL rnd_icmd n=%0d wr=%b addr=%h ben=%b exp wr=0 addr=%h ben=0000", n, mem_wr, mem_addr, mem_ben, ia); end
         end else if (g == 2) begin
            checks++; if ({mem_wr, mem_addr, mem_ben} !== {w, da, (w ? be : 4'd0)}) begin failures++; $display("FAIL rnd_dcmd n=%0d wr=%b addr=%h ben=%b exp wr=%b addr=%h ben=%b", n, mem_wr, mem_addr, mem_ben, w, da, w ? be : 4'd0); end
            if (w) begin
               checks++; if (mem_wdata !== wd) begin failures++; $display("FAIL rnd_wdata n=%0d got=%h exp=%h", n, mem_wdata, wd); end
            end
         end
         if (ip) iwait++;
         if (g == 1) begin
            checks++; if (iwait > LIMIT + 1) begin failures++; $display("FAIL rnd_starve n=%0d waited=%0d max=%0d", n, iwait, LIMIT + 1); end
         end
         commit(g);
         if (g == 1) ip = 0;
         if (g == 2) dp = 0;
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      rst = 1'b1; fill_all = 1'b1; pl_we = 1'b0; pl_idx = '0; pl_data = '0;
      drive_idle();
      for (int i = 0; i < 4096; i++) ref_mem[i] = init_word(i);
      @(posedge clk);
      #1 fill_all = 1'b0;
      test_reset();
      test_instr_only();
      test_data_wr_rd();
      test_contention();
      test_streak_clear();
      test_reset_mid_read();
      test_idle();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog time limit reached checks=%0d", checks);
      $fatal(1, "watchdog");
   end

endmodule
